irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller_if.sv | 30 +++
 rtl/irq_controller.sv | 104 ++++++++++
 tb/tb_irq_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// irq_controller_if
//   CPU-side bundle of the interrupt controller: the request/acknowledge
//   handshake with its vector and data words, and the small config bus.
//   master : CPU / bus side (drives turnOffIRQ and config writes)
//   slave  : irq_controller side
//   Ports: irq, turnOffIRQ, intAddr[N], intData[M],
//          cfgWE, cfgAddr[2], cfgWData[M], cfgRData[M]
interface irq_controller_if #(
    parameter int N = 32,
    parameter int M = 16
);
    logic         irq;
    logic         turnOffIRQ;
    logic [N-1:0] intAddr;
    logic [M-1:0] intData;
    logic         cfgWE;
    logic [1:0]   cfgAddr;
    logic [M-1:0] cfgWData;
    logic [M-1:0] cfgRData;

    modport master (
        input  irq, intAddr, intData, cfgRData,
        output turnOffIRQ, cfgWE, cfgAddr, cfgWData
    );

    modport slave (
        output irq, intAddr, intData, cfgRData,
        input  turnOffIRQ, cfgWE, cfgAddr, cfgWData
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
//   Rising-edge interrupt controller with per-source mask, software trigger
//   and fixed priority (source 0 highest). One request is committed at a
//   time: once irq rises it stays high until the CPU acknowledges it, then
//   a one-cycle holdoff separates it from the next request.
//   Ports: clk, rst (sync, active high), src[NSRC],
//          bus (irq_controller_if.slave): irq, turnOffIRQ, intAddr, intData,
//          cfgWE, cfgAddr, cfgWData, cfgRData
//   Config map: 0 MASK (rw), 1 PENDING (w1c), 2 SWTRIG (w1s, reads 0),
//               3 STATUS (ro: {irq, 11'b0, actIdx})
module irq_controller #(
    parameter int             NSRC     = 8,
    parameter int             N        = 32,
    parameter int             M        = 16,
    parameter logic [N-1:0]   VEC_BASE = N'(32'h0000_1000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} stateT;

    stateT           state, nextState;
    logic [NSRC-1:0] srcPrev, pending, mask;
    logic [NSRC-1:0] reqVec, actOneHot, setVec, clrVec, swSet, swClr;
    logic [3:0]      actIdx, lowIdx;
    logic            anyReq, moreLive, moreHeld, moreFlag, ackHit, irqInt;

    assign reqVec = pending & mask;
    assign anyReq = |reqVec;

    // Lowest set bit wins; scan from the top so the last hit is the lowest.
    always_comb begin
        lowIdx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (reqVec[i]) lowIdx = 4'(i);
    end

    always_comb begin
        actOneHot = '0;
        for (int i = 0; i < NSRC; i++)
            actOneHot[i] = (actIdx == 4'(i));
    end

    assign moreLive = |(reqVec & ~actOneHot);
    assign ackHit   = (state == ASSERT) && bus.turnOffIRQ;

    assign swSet  = (bus.cfgWE && bus.cfgAddr == 2'd2) ? bus.cfgWData[NSRC-1:0] : '0;
    assign swClr  = (bus.cfgWE && bus.cfgAddr == 2'd1) ? bus.cfgWData[NSRC-1:0] : '0;
    assign setVec = (src & ~srcPrev) | swSet;
    assign clrVec = swClr | (ackHit ? actOneHot : '0);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ASSERT;
            ASSERT:  if (bus.turnOffIRQ) nextState = HOLDOFF;
            HOLDOFF: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            srcPrev  <= '1;   // src already high at release is not an edge
            pending  <= '0;
            mask     <= '0;
            actIdx   <= '0;
            moreHeld <= 1'b0;
        end else begin
            state   <= nextState;
            srcPrev <= src;
            // Clear first, then set: a same-cycle set always survives.
            pending <= (pending & ~clrVec) | setVec;
            if (bus.cfgWE && bus.cfgAddr == 2'd0)
                mask <= bus.cfgWData[NSRC-1:0];
            if (state == IDLE && anyReq)
                actIdx <= lowIdx;
            // Freeze moreFlag as last seen in ASSERT so intData stays stable
            // after irq falls.
            if (state == ASSERT)
                moreHeld <= moreLive;
        end
    end

    assign irqInt   = (state == ASSERT);
    assign moreFlag = irqInt ? moreLive : moreHeld;

    assign bus.irq     = irqInt;
    assign bus.intAddr = VEC_BASE + (N'(actIdx) << 4);
    assign bus.intData = M'({moreFlag, 11'b0, actIdx});

    always_comb begin
        bus.cfgRData = '0;
        case (bus.cfgAddr)
            2'd0:    bus.cfgRData = M'(mask);
            2'd1:    bus.cfgRData = M'(pending);
            2'd2:    bus.cfgRData = '0;
            default: bus.cfgRData = M'({irqInt, 11'b0, actIdx});
        endcase
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Directed bench for irq_controller: inputs change on the falling edge,
//   outputs are sampled on the falling edge, so every check sees the state
//   left by the preceding rising edge.
module tb_irq_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    int         assertCount = 0;
    int         failCount   = 0;
    logic [15:0] rd;

    irq_controller_if #(.N(32), .M(16)) ifc ();

    irq_controller #(.NSRC(8), .N(32), .M(16), .VEC_BASE(32'h0000_1000)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; the write lands on the next rising edge.
    task automatic cfgWrite(input logic [1:0] a, input logic [15:0] d);
        ifc.cfgWE    = 1'b1;
        ifc.cfgAddr  = a;
        ifc.cfgWData = d;
        @(negedge clk);
        ifc.cfgWE    = 1'b0;
    endtask

    task automatic cfgRead(input logic [1:0] a, output logic [15:0] d);
        ifc.cfgAddr = a;
        #1;
        d = ifc.cfgRData;
    endtask

    task automatic ackPulse();
        ifc.turnOffIRQ = 1'b1;
        @(negedge clk);
        ifc.turnOffIRQ = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; src = '0;
        ifc.turnOffIRQ = 1'b0; ifc.cfgWE = 1'b0; ifc.cfgAddr = '0; ifc.cfgWData = '0;
        cyc(3);
        rst = 1'b0;
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL reset_irq: got %b want 0", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1000) begin failCount++; $display("FAIL reset_intAddr: got %h want 00001000", ifc.intAddr); end
        assertCount++; if (ifc.intData !== 16'h0000) begin failCount++; $display("FAIL reset_intData: got %h want 0000", ifc.intData); end
        cfgRead(2'd0, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL reset_mask: got %h want 0000", rd); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL reset_pending: got %h want 0000", rd); end
        cfgRead(2'd3, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL reset_status: got %h want 0000", rd); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL reset_no_spurious: got %b want 0", ifc.irq); end
    endtask

    task automatic test_basic();
        cfgWrite(2'd0, 16'h00FF);
        src = 8'h08;
        cyc(1);
        src = 8'h00;
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL basic_latency: got %b want 0", ifc.irq); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL basic_irq: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1030) begin failCount++; $display("FAIL basic_intAddr: got %h want 00001030", ifc.intAddr); end
        assertCount++; if (ifc.intData !== 16'h0003) begin failCount++; $display("FAIL basic_intData: got %h want 0003", ifc.intData); end
        ackPulse();
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL basic_ack_irq: got %b want 0", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1030) begin failCount++; $display("FAIL basic_addr_hold: got %h want 00001030", ifc.intAddr); end
        cfgRead(2'd3, rd);
        assertCount++; if (rd !== 16'h0003) begin failCount++; $display("FAIL basic_status: got %h want 0003", rd); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL basic_pending: got %h want 0000", rd); end
        cyc(1);
    endtask

    task automatic test_priority();
        src = 8'h24;
        cyc(1);
        src = 8'h00;
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL prio_irq1: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h8002) begin failCount++; $display("FAIL prio_data1: got %h want 8002", ifc.intData); end
        assertCount++; if (ifc.intAddr !== 32'h1020) begin failCount++; $display("FAIL prio_addr1: got %h want 00001020", ifc.intAddr); end
        ackPulse();
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL prio_gap1: got %b want 0", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h8002) begin failCount++; $display("FAIL prio_data_hold: got %h want 8002", ifc.intData); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL prio_gap2: got %b want 0", ifc.irq); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL prio_irq2: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h0005) begin failCount++; $display("FAIL prio_data2: got %h want 0005", ifc.intData); end
        ackPulse();
        cyc(1);
    endtask

    task automatic test_swtrig();
        cfgWrite(2'd0, 16'h0000);
        cfgWrite(2'd2, 16'h0010);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL sw_masked_irq: got %b want 0", ifc.irq); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0010) begin failCount++; $display("FAIL sw_pending: got %h want 0010", rd); end
        cfgRead(2'd2, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL sw_readzero: got %h want 0000", rd); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL sw_still_masked: got %b want 0", ifc.irq); end
        cfgWrite(2'd0, 16'h0010);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL sw_unmask_edge: got %b want 0", ifc.irq); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL sw_irq: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1040) begin failCount++; $display("FAIL sw_intAddr: got %h want 00001040", ifc.intAddr); end
        assertCount++; if (ifc.intData !== 16'h0004) begin failCount++; $display("FAIL sw_intData: got %h want 0004", ifc.intData); end
        ackPulse();
        cyc(1);
    endtask

    task automatic test_committed();
        cfgWrite(2'd0, 16'h0002);
        cfgWrite(2'd2, 16'h0002);
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL commit_irq: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1010) begin failCount++; $display("FAIL commit_addr: got %h want 00001010", ifc.intAddr); end
        cfgWrite(2'd0, 16'h0000);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL commit_after_mask: got %b want 1", ifc.irq); end
        cfgWrite(2'd1, 16'h0002);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL commit_after_clear: got %b want 1", ifc.irq); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL commit_pending: got %h want 0000", rd); end
        cyc(2);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL commit_hold: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h0001) begin failCount++; $display("FAIL commit_data: got %h want 0001", ifc.intData); end
        ackPulse();
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL commit_ack: got %b want 0", ifc.irq); end
        cyc(1);
        ackPulse();
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL idle_ack_irq: got %b want 0", ifc.irq); end
        cfgRead(2'd3, rd);
        assertCount++; if (rd !== 16'h0001) begin failCount++; $display("FAIL idle_ack_status: got %h want 0001", rd); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL idle_ack_later: got %b want 0", ifc.irq); end
    endtask

    task automatic test_back_to_back();
        cfgWrite(2'd0, 16'h0001);
        src = 8'h01;
        cyc(1);
        src = 8'h00;
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL race_irq1: got %b want 1", ifc.irq); end
        ifc.turnOffIRQ = 1'b1;
        src = 8'h01;
        cyc(1);
        ifc.turnOffIRQ = 1'b0;
        src = 8'h00;
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL race_holdoff: got %b want 0", ifc.irq); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0001) begin failCount++; $display("FAIL race_set_wins: got %h want 0001", rd); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL race_idle: got %b want 0", ifc.irq); end
        cyc(1);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL race_irq2: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h0000) begin failCount++; $display("FAIL race_data2: got %h want 0000", ifc.intData); end
        assertCount++; if (ifc.intAddr !== 32'h1000) begin failCount++; $display("FAIL race_addr2: got %h want 00001000", ifc.intAddr); end
        ackPulse();
        cyc(1);
    endtask

    task automatic test_reset_in_assert();
        cfgWrite(2'd0, 16'h0080);
        src = 8'h80;
        cyc(2);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL rstA_irq: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1070) begin failCount++; $display("FAIL rstA_addr: got %h want 00001070", ifc.intAddr); end
        rst = 1'b1;
        ifc.turnOffIRQ = 1'b1;
        ifc.cfgWE = 1'b1; ifc.cfgAddr = 2'd0; ifc.cfgWData = 16'h00FF;
        cyc(1);
        rst = 1'b0;
        ifc.turnOffIRQ = 1'b0;
        ifc.cfgWE = 1'b0;
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL rstA_drop: got %b want 0", ifc.irq); end
        assertCount++; if (ifc.intAddr !== 32'h1000) begin failCount++; $display("FAIL rstA_addr_reset: got %h want 00001000", ifc.intAddr); end
        assertCount++; if (ifc.intData !== 16'h0000) begin failCount++; $display("FAIL rstA_data_reset: got %h want 0000", ifc.intData); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL rstA_pending: got %h want 0000", rd); end
        cfgRead(2'd0, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL rstA_mask_prio: got %h want 0000", rd); end
        cfgWrite(2'd0, 16'h0080);
        cyc(2);
        assertCount++; if (ifc.irq !== 1'b0) begin failCount++; $display("FAIL rstA_no_new: got %b want 0", ifc.irq); end
        cfgRead(2'd1, rd);
        assertCount++; if (rd !== 16'h0000) begin failCount++; $display("FAIL rstA_no_pending: got %h want 0000", rd); end
        src = 8'h00;
        cyc(1);
        src = 8'h80;
        cyc(2);
        assertCount++; if (ifc.irq !== 1'b1) begin failCount++; $display("FAIL rstA_reedge: got %b want 1", ifc.irq); end
        assertCount++; if (ifc.intData !== 16'h0007) begin failCount++; $display("FAIL rstA_reedge_data: got %h want 0007", ifc.intData); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_swtrig();
        test_committed();
        test_back_to_back();
        test_reset_in_assert();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
